// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file:
// FSM encoding, hardwired-zero constants and the port-packing helper.
package regfile_mp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned ZERO_ADDR  = 0;
  localparam int unsigned MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

  // Low bit of lane i in a vector packed with lanes of width w.
  function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/regfile_mp_bypass.sv
// Per-read-port forwarding mux: picks the highest-index enabled write port
// whose address matches, so a write is visible to reads in the same cycle.
module regfile_mp_bypass
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        data,
  output logic                     hit
);

  always_comb begin
    data = ZERO_WORD[DATA_W-1:0];
    hit  = 1'b0;
    // Ascending scan, so the last match (highest index) wins.
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (we[i] && (waddr[slice_lo(i, ADDR_W) +: ADDR_W] == raddr)) begin
        data = wdata[slice_lo(i, DATA_W) +: DATA_W];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clear sweep,
// same-cycle write bypass and a per-register pending scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned NUM_WR      = 2,
  parameter int unsigned NUM_RD      = 4,
  parameter int unsigned CLR_PER_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR-1:0]        rsv_en,
  input  logic [NUM_WR*ADDR_W-1:0] rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend
);

  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned SWEEP_LAST = DEPTH - CLR_PER_CYC;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                sweep_done;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend;
  logic [NUM_WR-1:0]   we_run;

  // The last chunk starts at SWEEP_LAST; detecting it directly avoids
  // depending on the pointer wrapping back to 0.
  assign sweep_done = (state == ST_CLEAR) && (clr_ptr == ADDR_W'(SWEEP_LAST));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (sweep_done) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    ready = (state == ST_RUN) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                    clr_ptr <= '0;
    else if (state == ST_CLEAR) clr_ptr <= clr_ptr + ADDR_W'(CLR_PER_CYC);
  end

  assign we_run = ready ? we : '0;

  // Storage has no reset of its own; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      for (int unsigned k = 0; k < CLR_PER_CYC; k++) begin
        mem[clr_ptr + ADDR_W'(k)] <= ZERO_WORD[DATA_W-1:0];
      end
    end else begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (we_run[i] && waddr[slice_lo(i, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_ADDR)) begin
          mem[waddr[slice_lo(i, ADDR_W) +: ADDR_W]] <= wdata[slice_lo(i, DATA_W) +: DATA_W];
        end
      end
    end
  end

  // Reservations are applied after write clears so a same-cycle reserve wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (ready) begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (we[i] && waddr[slice_lo(i, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_ADDR)) begin
          pend[waddr[slice_lo(i, ADDR_W) +: ADDR_W]] <= 1'b0;
        end
      end
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (rsv_en[i] && rsv_addr[slice_lo(i, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_ADDR)) begin
          pend[rsv_addr[slice_lo(i, ADDR_W) +: ADDR_W]] <= 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] byp_data;
    logic              byp_hit;
    logic              live;

    assign ra   = raddr[j*ADDR_W +: ADDR_W];
    assign live = ready && (ra != ADDR_W'(ZERO_ADDR));

    regfile_mp_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .we    (we_run),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (ra),
      .data  (byp_data),
      .hit   (byp_hit)
    );

    assign rdata[j*DATA_W +: DATA_W] = !live  ? ZERO_WORD[DATA_W-1:0] :
                                       byp_hit ? byp_data : mem[ra];
    assign rpend[j] = live && !byp_hit && pend[ra];
  end

endmodule
